// File: rtl/fx2_pkg.sv
// rtl/fx2_pkg.sv - shared FX2 slave-FIFO states, endpoint addresses and sync header
package fx2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    SETUP,
    OE,
    RD,
    GAP,
    REL
  } state_e;

  localparam logic [1:0]  EP2_ADDR           = 2'b00;
  localparam logic [1:0]  EP6_ADDR           = 2'b10;
  localparam logic [15:0] SYNC_WORD_DEFAULT  = 16'h7F7F;

endpackage

// File: rtl/fx2_ep2_reader.sv
// rtl/fx2_ep2_reader.sv - EP2 OUT FIFO drain to FPGA FIFO; FX2_EP2_SYNC_HUNT_EN adds header hunt
module fx2_ep2_reader
  import fx2_pkg::*;
#(
  parameter logic [1:0]  EP_ADDR   = EP2_ADDR,
  parameter int          MAX_BURST = 256
`ifdef FX2_EP2_SYNC_HUNT_EN
  ,
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT
`endif
) (
  input  logic        IFCLK,
  input  logic        RESET,
  input  logic [15:0] FD_IN,
  input  logic        EP2_EMPTY_N,
  output logic        SLRD,
  output logic        SLOE,
  output logic [1:0]  FIFO_ADR,
  output logic        REQ,
  input  logic        GNT,
  output logic [15:0] DOUT,
  output logic        DOUT_WR,
  input  logic        DOUT_FULL,
  output logic [15:0] WORD_CNT,
  output logic        SYNC_LOCK
);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        sloe_q, sloe_d;
  logic        slrd_q, slrd_d;
  logic [15:0] dout_q, dout_d;
  logic        dout_wr_q, dout_wr_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [16:0] burst_q, burst_d;
  logic        fwd;

`ifdef FX2_EP2_SYNC_HUNT_EN
  logic lock_q, lock_d;
  assign fwd       = lock_q || (FD_IN == SYNC_WORD);
  assign SYNC_LOCK = lock_q;
`else
  assign fwd       = 1'b1;
  assign SYNC_LOCK = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    sloe_d     = sloe_q;
    slrd_d     = 1'b1;
    dout_d     = dout_q;
    dout_wr_d  = 1'b0;
    word_cnt_d = word_cnt_q;
    burst_d    = burst_q;
`ifdef FX2_EP2_SYNC_HUNT_EN
    lock_d     = lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (EP2_EMPTY_N && !DOUT_FULL) begin
          req_d   = 1'b1;
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (GNT) state_d = SETUP;
      end
      SETUP: begin
        sloe_d  = 1'b0;
        state_d = OE;
      end
      OE: begin
        burst_d = '0;
        // The flag may have dropped while we waited for the bus.
        if (EP2_EMPTY_N) begin
          slrd_d  = 1'b0;
          state_d = RD;
        end else begin
          sloe_d  = 1'b1;
          state_d = REL;
        end
      end
      RD: begin
        burst_d = burst_q + 17'd1;
        state_d = GAP;
        if (fwd) begin
          dout_d     = FD_IN;
          dout_wr_d  = 1'b1;
          word_cnt_d = word_cnt_q + 16'd1;
`ifdef FX2_EP2_SYNC_HUNT_EN
          lock_d     = 1'b1;
`endif
        end
      end
      GAP: begin
        if (EP2_EMPTY_N && !DOUT_FULL && GNT && (burst_q < 17'(MAX_BURST))) begin
          slrd_d  = 1'b0;
          state_d = RD;
        end else begin
          sloe_d  = 1'b1;
          state_d = REL;
        end
      end
      REL: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge IFCLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      sloe_q     <= 1'b1;
      slrd_q     <= 1'b1;
      dout_q     <= '0;
      dout_wr_q  <= 1'b0;
      word_cnt_q <= '0;
      burst_q    <= '0;
`ifdef FX2_EP2_SYNC_HUNT_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      sloe_q     <= sloe_d;
      slrd_q     <= slrd_d;
      dout_q     <= dout_d;
      dout_wr_q  <= dout_wr_d;
      word_cnt_q <= word_cnt_d;
      burst_q    <= burst_d;
`ifdef FX2_EP2_SYNC_HUNT_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign SLRD     = slrd_q;
  assign SLOE     = sloe_q;
  assign REQ      = req_q;
  assign DOUT     = dout_q;
  assign DOUT_WR  = dout_wr_q;
  assign WORD_CNT = word_cnt_q;
  assign FIFO_ADR = EP_ADDR;

endmodule
